// File: rtl/mult_seq_pkg.sv
// Shared definitions for the nibble-sequenced 8x8 multiplier: state encoding,
// pass count and the per-pass operand-nibble / shift schedule.
package mult_seq_pkg;

  localparam int OP_W       = 8;
  localparam int SLICE_W    = 4;
  localparam int PROD_W     = 2 * OP_W;
  localparam int NUM_PASSES = 4;

  // 2'd3 is deliberately left unnamed; the FSM treats it as illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One row of the pass schedule: which nibble of each operand feeds the slice,
  // and how far the slice product is shifted before accumulation.
  typedef struct packed {
    logic       a_hi;
    logic       b_hi;
    logic [3:0] shift;
  } pass_sched_t;

  // Pass schedule lookup; partial products cover lo*lo, hi*lo, lo*hi, hi*hi.
  function automatic pass_sched_t pass_sched(input logic [1:0] pass);
    pass_sched_t s;
    case (pass)
      2'd0:    s = '{a_hi: 1'b0, b_hi: 1'b0, shift: 4'd0};
      2'd1:    s = '{a_hi: 1'b1, b_hi: 1'b0, shift: 4'd4};
      2'd2:    s = '{a_hi: 1'b0, b_hi: 1'b1, shift: 4'd4};
      2'd3:    s = '{a_hi: 1'b1, b_hi: 1'b1, shift: 4'd8};
      default: s = '{a_hi: 1'b0, b_hi: 1'b0, shift: 4'd0};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mult8_seq_ctrl_if.sv
// Operand/result handshake bundle for mult8_seq_ctrl.
// master = operand producer / result consumer side, slave = the sequencer.
interface mult8_seq_ctrl_if;
  import mult_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] product;
  logic              busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/mult8_seq_ctrl_array_mult.sv
// Existing 4x4 unsigned combinational array multiplier, reused as the shared slice.
// Each multiplier bit gates a copy of x; the gated rows are summed with their weights.
module array_mult_structural (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);

  logic [7:0] pp [4];

  for (genvar i = 0; i < 4; i++) begin : g_pp
    assign pp[i] = {4'd0, (x & {4{y[i]}})} << i;
  end

  assign p = pp[0] + pp[1] + pp[2] + pp[3];

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequencer producing an unsigned 8x8 -> 16 product from four passes through a
// single shared 4x4 multiplier slice, with valid/ready on both sides.
module mult8_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int OP_W_P    = OP_W,
  parameter int SLICE_W_P = SLICE_W
) (
  input  logic            clk,
  input  logic            rst,
  mult8_seq_ctrl_if.slave bus
);

  state_e              state_q, state_d;
  logic [1:0]          pass_cnt_q, pass_cnt_d;
  logic [OP_W_P-1:0]   a_q, a_d;
  logic [OP_W_P-1:0]   b_q, b_d;
  logic [PROD_W-1:0]   acc_q, acc_d;

  pass_sched_t         sched;
  logic [SLICE_W_P-1:0]   slice_x, slice_y;
  logic [2*SLICE_W_P-1:0] mul_p;

  assign sched = pass_sched(pass_cnt_q);

  // Slice operand mux: selected nibbles during MUL, held at zero otherwise to avoid toggling.
  always_comb begin
    slice_x = {SLICE_W_P{1'b0}};
    slice_y = {SLICE_W_P{1'b0}};
    if (state_q == ST_MUL) begin
      slice_x = sched.a_hi ? a_q[OP_W_P-1:SLICE_W_P] : a_q[SLICE_W_P-1:0];
      slice_y = sched.b_hi ? b_q[OP_W_P-1:SLICE_W_P] : b_q[SLICE_W_P-1:0];
    end else begin
      slice_x = {SLICE_W_P{1'b0}};
      slice_y = {SLICE_W_P{1'b0}};
    end
  end

  array_mult_structural u_slice (
    .x (slice_x),
    .y (slice_y),
    .p (mul_p)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pass_cnt_q <= 2'd0;
      a_q        <= {OP_W_P{1'b0}};
      b_q        <= {OP_W_P{1'b0}};
      acc_q      <= {PROD_W{1'b0}};
    end else begin
      state_q    <= state_d;
      pass_cnt_q <= pass_cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
    end
  end

  // Next-state and datapath update: latch on accept, accumulate one pass per MUL cycle.
  always_comb begin
    state_d    = state_q;
    pass_cnt_d = pass_cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.a;
          b_d        = bus.b;
          acc_d      = {PROD_W{1'b0}};
          pass_cnt_d = 2'd0;
          state_d    = ST_MUL;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_MUL: begin
        // Max total is 255*255, so the 16-bit accumulator cannot wrap.
        acc_d      = acc_q + ({{(PROD_W-2*SLICE_W_P){1'b0}}, mul_p} << sched.shift);
        pass_cnt_d = pass_cnt_q + 2'd1;
        if (pass_cnt_q == 2'(NUM_PASSES - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        pass_cnt_d = 2'd0;
      end
    endcase
  end

  // Handshake outputs decoded from the registered state; product is the accumulator.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.product   = acc_q;
    case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
      end
      ST_MUL: begin
        bus.busy = 1'b1;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: begin
        bus.in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Directed and randomized-stream bench for mult8_seq_ctrl.
module tb_mult8_seq_ctrl;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mult8_seq_ctrl_if bus_if ();

  mult8_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one operand pair (caller is at #1 after an edge with in_ready=1) and
  // wait for out_valid; lat counts edges after the accept edge.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        output logic [15:0] p, output int lat);
    bus_if.a        = av;
    bus_if.b        = bv;
    bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    bus_if.a        = 8'h00;
    bus_if.b        = 8'h00;
    lat = 0;
    while (bus_if.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    p = bus_if.product;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus_if.in_ready); end
    checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus_if.out_valid); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
    checks++; if (bus_if.product !== 16'h0000) begin errors++; $display("FAIL reset_product got=%h exp=0000", bus_if.product); end
  endtask

  task automatic test_single();
    logic [15:0] p;
    int lat;
    bus_if.out_ready = 1'b1;
    run_op(8'hFF, 8'hFF, p, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL single_latency got=%0d exp=4", lat); end
    checks++; if (p !== 16'hFE01) begin errors++; $display("FAIL single_product got=%h exp=fe01", p); end
    checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL single_busy_done got=%b exp=1", bus_if.busy); end
    @(posedge clk); #1;
    checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL single_back_idle got=%b exp=1", bus_if.in_ready); end
    checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got=%b exp=0", bus_if.out_valid); end
  endtask

  task automatic test_nibbles();
    logic [7:0]  av [4];
    logic [7:0]  bv [4];
    logic [15:0] ev [4];
    logic [15:0] p;
    int lat;
    av[0] = 8'h10; bv[0] = 8'h01; ev[0] = 16'h0010;
    av[1] = 8'h01; bv[1] = 8'h10; ev[1] = 16'h0010;
    av[2] = 8'h10; bv[2] = 8'h10; ev[2] = 16'h0100;
    av[3] = 8'h00; bv[3] = 8'hAB; ev[3] = 16'h0000;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_op(av[i], bv[i], p, lat);
      checks++;
      if (p !== ev[i] || lat !== 4) begin
        errors++;
        $display("FAIL nibble_%0d a=%h b=%h got=%h lat=%0d exp=%h lat=4", i, av[i], bv[i], p, lat, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] p;
    int lat;
    int bad_hold;
    bus_if.out_ready = 1'b0;
    run_op(8'd12, 8'd13, p, lat);
    checks++; if (p !== 16'd156 || lat !== 4) begin errors++; $display("FAIL bp_product got=%0d lat=%0d exp=156 lat=4", p, lat); end
    bad_hold = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus_if.out_valid !== 1'b1 || bus_if.product !== 16'd156 || bus_if.in_ready !== 1'b0) bad_hold++;
    end
    checks++; if (bad_hold != 0) begin errors++; $display("FAIL bp_hold got=%0d bad cycles exp=0", bad_hold); end
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", bus_if.out_valid, bus_if.in_ready);
    end
  endtask

  task automatic test_reset_midop();
    logic [15:0] p;
    int lat;
    int seen_valid;
    bus_if.out_ready = 1'b1;
    bus_if.a = 8'h37; bus_if.b = 8'h5A; bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus_if.in_ready !== 1'b1 || bus_if.product !== 16'h0000) begin
      errors++; $display("FAIL midrst_state got ready=%b product=%h exp ready=1 product=0000", bus_if.in_ready, bus_if.product);
    end
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus_if.out_valid === 1'b1) seen_valid++;
      @(posedge clk); #1;
    end
    checks++; if (seen_valid != 0) begin errors++; $display("FAIL midrst_no_valid got=%0d exp=0", seen_valid); end
    run_op(8'd3, 8'd4, p, lat);
    checks++; if (p !== 16'd12 || lat !== 4) begin errors++; $display("FAIL midrst_next got=%0d lat=%0d exp=12 lat=4", p, lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    logic [15:0] exp_q [$];
    int received;
    bit prod_timeout;
    received = 0;
    prod_timeout = 1'b0;
    fork
      begin : producer
        for (int i = 0; i < 1000 && !prod_timeout; i++) begin
          logic [7:0] av, bv;
          int wait_cnt;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          av = 8'($urandom_range(0, 255));
          bv = 8'($urandom_range(0, 255));
          bus_if.a = av; bus_if.b = bv; bus_if.in_valid = 1'b1;
          wait_cnt = 0;
          while (bus_if.in_ready !== 1'b1 && wait_cnt < 200) begin
            @(posedge clk); #1;
            wait_cnt++;
          end
          if (wait_cnt >= 200) begin
            prod_timeout = 1'b1;
          end else begin
            exp_q.push_back(16'(av) * 16'(bv));
            @(posedge clk); #1;
          end
          bus_if.in_valid = 1'b0;
          bus_if.a = 8'($urandom_range(0, 255));
          bus_if.b = 8'($urandom_range(0, 255));
        end
      end
      begin : consumer
        int cyc;
        cyc = 0;
        while (received < 1000 && cyc < 40000) begin
          @(posedge clk); #1;
          cyc++;
          bus_if.out_ready = ($urandom_range(0, 3) != 0);
          if (bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL stream_extra got=%h exp=none", bus_if.product);
            end else begin
              logic [15:0] e;
              e = exp_q.pop_front();
              if (bus_if.product !== e) begin
                errors++;
                $display("FAIL stream_%0d got=%h exp=%h", received, bus_if.product, e);
              end
            end
            received++;
          end
        end
      end
    join
    checks++; if (received != 1000 || exp_q.size() != 0 || prod_timeout) begin
      errors++; $display("FAIL stream_count got=%0d leftover=%0d timeout=%0d exp=1000 leftover=0 timeout=0", received, exp_q.size(), prod_timeout);
    end
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.a         = 8'h00;
    bus_if.b         = 8'h00;
    bus_if.out_ready = 1'b0;
    test_reset();
    test_single();
    test_nibbles();
    test_backpressure();
    test_reset_midop();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
